// File: rtl/soc_reset_sequencer.sv
// Purpose: board reset sequencer, PLL lock -> DDR3 reset release -> DDR3 init -> SoC reset release, plus timed PHY reset.
// Latency: 3 clocks pin-to-state (2-flop sync + state register); outputs registered from next state, same edge as state.
// Backpressure: none, free-running; `define RST_SEQ_WDOG_EN builds the DDR init watchdog and retry counter.
module soc_reset_sequencer #(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int DDR_RST_CYCLES      = 10000,
    parameter int PHY_RST_CYCLES      = 500000,
    parameter int SOC_DELAY_CYCLES    = 1000,
    parameter int INIT_TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W               = 26
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_in,
    input  logic       pll_lock,
    input  logic       ddr3_init_done,
    output logic       ddr3_rstn,
    output logic       phy_rstn,
    output logic       soc_rstn,
    output logic [2:0] seq_state,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_DDR_RST   = 3'd1,
        S_DDR_INIT  = 3'd2,
        S_SOC_DLY   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DDR_LAST = CNT_W'(DDR_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHY_LAST = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOC_LAST = CNT_W'(SOC_DELAY_CYCLES - 1);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > DDR_RST_CYCLES) ? DEBOUNCE_CYCLES : DDR_RST_CYCLES;
    localparam int MAX_CD  = (PHY_RST_CYCLES > SOC_DELAY_CYCLES) ? PHY_RST_CYCLES : SOC_DELAY_CYCLES;
    localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAX_ALL = (MAX_ABCD > INIT_TIMEOUT_CYCLES) ? MAX_ABCD : INIT_TIMEOUT_CYCLES;

    // Every counter reload value (N-1) has to fit in CNT_W bits.
    if (longint'(MAX_ALL) > (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("soc_reset_sequencer: CNT_W too narrow for configured cycle counts");
    end

    logic [1:0]       key_sync_q, key_sync_d;
    logic [1:0]       lock_sync_q, lock_sync_d;
    logic [1:0]       init_sync_q, init_sync_d;
    logic             key_db_q, key_db_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] phy_cnt_q, phy_cnt_d;
    logic             phy_run_q, phy_run_d;
    logic             phy_done_q, phy_done_d;
    logic             ddr3_rstn_q, ddr3_rstn_d;
    logic             phy_rstn_q, phy_rstn_d;
    logic             soc_rstn_q, soc_rstn_d;

    logic key_s, lock_s, init_s;

    assign key_s  = key_sync_q[1];
    assign lock_s = lock_sync_q[1];
    assign init_s = init_sync_q[1];

    // Synchronizer shift and key debounce: filtered key follows key_s only after a full stable window.
    always_comb begin
        key_sync_d  = {key_sync_q[0], key_in};
        lock_sync_d = {lock_sync_q[0], pll_lock};
        init_sync_d = {init_sync_q[0], ddr3_init_done};
        key_db_d    = key_db_q;
        db_cnt_d    = '0;
        if (key_s != key_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_db_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Input synchronizers and debounce state; key filter resets to released (1).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            key_sync_q  <= 2'b11;
            lock_sync_q <= 2'b00;
            init_sync_q <= 2'b00;
            key_db_q    <= 1'b1;
            db_cnt_q    <= '0;
        end else begin
            key_sync_q  <= key_sync_d;
            lock_sync_q <= lock_sync_d;
            init_sync_q <= init_sync_d;
            key_db_q    <= key_db_d;
            db_cnt_q    <= db_cnt_d;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT_CYCLES - 1);
    logic [3:0] retry_q, retry_d;
`endif

    // Next state, timed-state counter, PHY reset timer and output decode from the next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_LOCK: if (lock_s && key_db_q) state_d = S_DDR_RST;
            S_DDR_RST:   if (cnt_q == '0) state_d = S_DDR_INIT;
            S_DDR_INIT: begin
                if (init_s) begin
                    state_d = S_SOC_DLY;
                end
`ifdef RST_SEQ_WDOG_EN
                else if (cnt_q == '0) begin
                    state_d = S_DDR_RST;
                end
`endif
            end
            S_SOC_DLY: begin
                if (!init_s) state_d = S_DDR_INIT;
                else if (cnt_q == '0) state_d = S_RUN;
            end
            S_RUN:       if (!init_s) state_d = S_DDR_INIT;
            default:     state_d = S_WAIT_LOCK;
        endcase
        // Lost lock or a pressed key pulls everything back, overriding the normal flow.
        if ((state_q != S_WAIT_LOCK) && (!lock_s || !key_db_q)) state_d = S_WAIT_LOCK;

        // Shared down-counter: reload N-1 on entry, the state exits on the cycle it reads 0.
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                S_DDR_RST:  cnt_d = DDR_LAST;
                S_SOC_DLY:  cnt_d = SOC_LAST;
`ifdef RST_SEQ_WDOG_EN
                S_DDR_INIT: cnt_d = INIT_LAST;
`endif
                default:    cnt_d = '0;
            endcase
        end

`ifdef RST_SEQ_WDOG_EN
        retry_d = retry_q;
        if ((state_q == S_DDR_INIT) && (state_d == S_DDR_RST) && (retry_q != 4'hF)) begin
            retry_d = retry_q + 1'b1;
        end
`endif

        // PHY timer starts when the sequence leaves S_WAIT_LOCK and is wiped on every return to it.
        phy_cnt_d  = phy_cnt_q;
        phy_run_d  = phy_run_q;
        phy_done_d = phy_done_q;
        if ((state_q == S_WAIT_LOCK) && (state_d != S_WAIT_LOCK)) begin
            phy_cnt_d  = PHY_LAST;
            phy_run_d  = 1'b1;
            phy_done_d = 1'b0;
        end else if (state_d == S_WAIT_LOCK) begin
            phy_cnt_d  = '0;
            phy_run_d  = 1'b0;
            phy_done_d = 1'b0;
        end else if (phy_run_q) begin
            if (phy_cnt_q == '0) begin
                phy_run_d  = 1'b0;
                phy_done_d = 1'b1;
            end else begin
                phy_cnt_d = phy_cnt_q - 1'b1;
            end
        end

        ddr3_rstn_d = (state_d == S_DDR_INIT) || (state_d == S_SOC_DLY) || (state_d == S_RUN);
        soc_rstn_d  = (state_d == S_RUN);
        phy_rstn_d  = phy_done_q && (state_d != S_WAIT_LOCK);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            phy_cnt_q   <= '0;
            phy_run_q   <= 1'b0;
            phy_done_q  <= 1'b0;
            ddr3_rstn_q <= 1'b0;
            phy_rstn_q  <= 1'b0;
            soc_rstn_q  <= 1'b0;
`ifdef RST_SEQ_WDOG_EN
            retry_q     <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_cnt_q   <= phy_cnt_d;
            phy_run_q   <= phy_run_d;
            phy_done_q  <= phy_done_d;
            ddr3_rstn_q <= ddr3_rstn_d;
            phy_rstn_q  <= phy_rstn_d;
            soc_rstn_q  <= soc_rstn_d;
`ifdef RST_SEQ_WDOG_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign ddr3_rstn = ddr3_rstn_q;
    assign phy_rstn  = phy_rstn_q;
    assign soc_rstn  = soc_rstn_q;
    assign seq_state = state_q;
`ifdef RST_SEQ_WDOG_EN
    assign retry_cnt = retry_q;
`else
    assign retry_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Bench for soc_reset_sequencer: timestamp-based reference model compared every cycle,
// plus hand-computed checkpoints (edge numbers below count rising edges from 0).
// Honours RST_SEQ_WDOG_EN to select the watchdog expectations.
module tb_soc_reset_sequencer;

    localparam int DB  = 4;
    localparam int DDR = 8;
    localparam int PHY = 16;
    localparam int SOC = 4;
    localparam int TMO = 32;
    localparam int HN  = 4096;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       key_in = 1'b1;
    logic       pll_lock = 1'b0;
    logic       ddr3_init_done = 1'b0;
    logic       ddr3_rstn, phy_rstn, soc_rstn;
    logic [2:0] seq_state;
    logic [3:0] retry_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = -1;
    bit done  = 1'b0;

    soc_reset_sequencer #(
        .DEBOUNCE_CYCLES(DB), .DDR_RST_CYCLES(DDR), .PHY_RST_CYCLES(PHY),
        .SOC_DELAY_CYCLES(SOC), .INIT_TIMEOUT_CYCLES(TMO), .CNT_W(8)
    ) dut (
        .clk(clk), .rstn(rstn), .key_in(key_in), .pll_lock(pll_lock),
        .ddr3_init_done(ddr3_init_done), .ddr3_rstn(ddr3_rstn), .phy_rstn(phy_rstn),
        .soc_rstn(soc_rstn), .seq_state(seq_state), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pin histories, state entry timestamps, no down-counters.
    bit lock_h [HN];
    bit key_h  [HN];
    bit init_h [HN];
    int last_rst   = -10;
    int m_state    = 0;
    int m_t_enter  = 0;
    int m_t_leave  = 0;
    int m_retry    = 0;
    int m_diff_beg = -1;
    bit m_kdb      = 1'b1;
    bit m_ddr = 1'b0, m_phy = 1'b0, m_soc = 1'b0;

    always @(posedge clk) begin
        int n;
        int nxt;
        bit ls, ks, is;
        cyc = cyc + 1;
        n = cyc;
        if (n < HN) begin
            lock_h[n] = pll_lock;
            key_h[n]  = key_in;
            init_h[n] = ddr3_init_done;
        end
        if (!rstn) begin
            last_rst   = n;
            m_state    = 0;
            m_retry    = 0;
            m_kdb      = 1'b1;
            m_diff_beg = -1;
            m_ddr = 1'b0; m_phy = 1'b0; m_soc = 1'b0;
        end else begin
            // A pin value is visible to the sequencer two edges after it was sampled.
            ls = (n - 2 > last_rst) ? lock_h[n-2] : 1'b0;
            ks = (n - 2 > last_rst) ? key_h[n-2]  : 1'b1;
            is = (n - 2 > last_rst) ? init_h[n-2] : 1'b0;
            nxt = m_state;
            case (m_state)
                0: if (ls && m_kdb) nxt = 1;
                1: if (n - m_t_enter >= DDR) nxt = 2;
                2: begin
                    if (is) nxt = 3;
`ifdef RST_SEQ_WDOG_EN
                    else if (n - m_t_enter >= TMO) nxt = 1;
`endif
                end
                3: if (!is) nxt = 2; else if (n - m_t_enter >= SOC) nxt = 4;
                4: if (!is) nxt = 2;
                default: nxt = 0;
            endcase
            if (m_state != 0 && (!ls || !m_kdb)) nxt = 0;
            if (m_state == 2 && nxt == 1 && m_retry < 15) m_retry = m_retry + 1;
            if (nxt != m_state) m_t_enter = n;
            if (m_state == 0 && nxt != 0) m_t_leave = n;
            if (ks != m_kdb) begin
                if (m_diff_beg < 0) m_diff_beg = n;
                if (n - m_diff_beg + 1 >= DB) begin
                    m_kdb = ks;
                    m_diff_beg = -1;
                end
            end else begin
                m_diff_beg = -1;
            end
            m_state = nxt;
            m_ddr = (nxt >= 2);
            m_soc = (nxt == 4);
            m_phy = (nxt != 0) && (n >= m_t_leave + PHY + 1);
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc >= 0 && !done) begin
            tests = tests + 1;
            if ({seq_state, ddr3_rstn, phy_rstn, soc_rstn, retry_cnt} !==
                {3'(m_state), m_ddr, m_phy, m_soc, 4'(m_retry)}) begin
                fails = fails + 1;
                $display("FAIL model cyc=%0d state %0d/%0d ddr %b/%b phy %b/%b soc %b/%b retry %0d/%0d (got/exp)",
                         cyc, seq_state, m_state, ddr3_rstn, m_ddr, phy_rstn, m_phy,
                         soc_rstn, m_soc, retry_cnt, m_retry);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Return 1 time unit after rising edge k.
    task automatic go_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Park at the falling edge inside cycle k.
    task automatic at_edge(input int k);
        go_to(k);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d got no finish expected finish", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        at_edge(1);
        check("rst_state", int'(seq_state), 0);
        check("rst_ddr", int'(ddr3_rstn), 0);
        check("rst_phy", int'(phy_rstn), 0);
        check("rst_soc", int'(soc_rstn), 0);
        check("rst_retry", int'(retry_cnt), 0);
        go_to(2);  rstn = 1'b1;

        // Boot
        go_to(10); pll_lock = 1'b1;
        at_edge(20); check("boot_ddr_lo", int'(ddr3_rstn), 0);
        at_edge(21); check("boot_ddr_hi", int'(ddr3_rstn), 1); check("boot_st2", int'(seq_state), 2);
        at_edge(29); check("boot_phy_lo", int'(phy_rstn), 0);
        at_edge(30); check("boot_phy_hi", int'(phy_rstn), 1);
        go_to(40); ddr3_init_done = 1'b1;
        at_edge(46); check("boot_soc_lo", int'(soc_rstn), 0); check("boot_st3", int'(seq_state), 3);
        at_edge(47); check("boot_soc_hi", int'(soc_rstn), 1); check("boot_st4", int'(seq_state), 4);

        // Key glitch (3 cycles) is filtered
        go_to(60); key_in = 1'b0;
        go_to(63); key_in = 1'b1;
        at_edge(75); check("glitch_soc", int'(soc_rstn), 1); check("glitch_st", int'(seq_state), 4);

        // Key press (6 cycles) resets, then reboot after release + debounce
        go_to(80); key_in = 1'b0;
        go_to(86); key_in = 1'b1;
        at_edge(86); check("press_soc_pre", int'(soc_rstn), 1);
        at_edge(87); check("press_st", int'(seq_state), 0); check("press_ddr", int'(ddr3_rstn), 0);
        check("press_phy", int'(phy_rstn), 0); check("press_soc", int'(soc_rstn), 0);
        at_edge(92);  check("rel_hold", int'(seq_state), 0);
        at_edge(93);  check("rel_go", int'(seq_state), 1);
        at_edge(101); check("rel_ddr", int'(ddr3_rstn), 1);
        at_edge(105); check("rel_soc_lo", int'(soc_rstn), 0);
        at_edge(106); check("rel_soc_hi", int'(soc_rstn), 1);
        at_edge(109); check("rel_phy_lo", int'(phy_rstn), 0);
        at_edge(110); check("rel_phy_hi", int'(phy_rstn), 1);

        // Lock loss in S_RUN, then lock return
        go_to(120); pll_lock = 1'b0;
        at_edge(122); check("ll_soc_pre", int'(soc_rstn), 1);
        at_edge(123); check("ll_st", int'(seq_state), 0); check("ll_ddr", int'(ddr3_rstn), 0);
        check("ll_phy", int'(phy_rstn), 0); check("ll_soc", int'(soc_rstn), 0);
        go_to(130); pll_lock = 1'b1;
        at_edge(141); check("lr_ddr", int'(ddr3_rstn), 1);
        at_edge(146); check("lr_soc", int'(soc_rstn), 1);
        at_edge(150); check("lr_phy", int'(phy_rstn), 1);

        // Init drop in S_RUN
        go_to(160); ddr3_init_done = 1'b0;
        at_edge(162); check("id_soc_pre", int'(soc_rstn), 1);
        at_edge(163); check("id_soc", int'(soc_rstn), 0); check("id_ddr", int'(ddr3_rstn), 1);
        check("id_phy", int'(phy_rstn), 1); check("id_st", int'(seq_state), 2);
        go_to(170); ddr3_init_done = 1'b1;
        at_edge(176); check("ir_soc_lo", int'(soc_rstn), 0);
        at_edge(177); check("ir_soc_hi", int'(soc_rstn), 1);

        // Init never comes back
        go_to(190); ddr3_init_done = 1'b0;
        at_edge(193); check("wd_st2", int'(seq_state), 2);
`ifdef RST_SEQ_WDOG_EN
        at_edge(224); check("wd_ddr_hi", int'(ddr3_rstn), 1); check("wd_retry0", int'(retry_cnt), 0);
        at_edge(225); check("wd_ddr_lo", int'(ddr3_rstn), 0); check("wd_st1", int'(seq_state), 1);
        check("wd_retry1", int'(retry_cnt), 1);
        at_edge(232); check("wd_ddr_lo8", int'(ddr3_rstn), 0);
        at_edge(233); check("wd_ddr_back", int'(ddr3_rstn), 1);
        at_edge(265); check("wd_retry2", int'(retry_cnt), 2); check("wd_ddr_lo2", int'(ddr3_rstn), 0);
        at_edge(784); check("wd_retry14", int'(retry_cnt), 14);
        at_edge(785); check("wd_retry15", int'(retry_cnt), 15);
        at_edge(830); check("wd_retry_sat", int'(retry_cnt), 15); check("wd_st_rst", int'(seq_state), 1);
`else
        at_edge(300); check("nowd_st", int'(seq_state), 2); check("nowd_ddr", int'(ddr3_rstn), 1);
        check("nowd_retry", int'(retry_cnt), 0);
        at_edge(830); check("nowd_st_late", int'(seq_state), 2); check("nowd_retry_late", int'(retry_cnt), 0);
`endif

        // rstn asserted during S_SOC_DLY, then clean reboot
        go_to(840); ddr3_init_done = 1'b1;
        at_edge(844); check("sr_st3", int'(seq_state), 3);
        rstn = 1'b0;
        at_edge(845); check("sr_st0", int'(seq_state), 0); check("sr_ddr", int'(ddr3_rstn), 0);
        check("sr_phy", int'(phy_rstn), 0); check("sr_soc", int'(soc_rstn), 0);
        check("sr_retry", int'(retry_cnt), 0);
        rstn = 1'b1;
        at_edge(847); check("rb_st0", int'(seq_state), 0);
        at_edge(848); check("rb_st1", int'(seq_state), 1);
        at_edge(856); check("rb_ddr", int'(ddr3_rstn), 1);
        at_edge(861); check("rb_soc", int'(soc_rstn), 1);
        at_edge(864); check("rb_phy_lo", int'(phy_rstn), 0);
        at_edge(865); check("rb_phy_hi", int'(phy_rstn), 1);

        at_edge(880);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
